// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule definitions: round count, state
//               encoding, round-constant lookup and word/byte slicing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2
  } state_t;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Word idx of a 128-bit block; word 0 sits in the most significant bits.
  function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  // Byte bcnt of RotWord(w): the word rotated left by one byte.
  function automatic logic [7:0] rot_byte(input logic [31:0] w, input logic [1:0] bcnt);
    logic [7:0] b;
    case (bcnt)
      2'd0:    b = w[23:16];
      2'd1:    b = w[15:8];
      2'd2:    b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/Sbox.sv
// ============================================================================
// Module      : Sbox
// Description : Combinational AES forward S-box (SubBytes byte substitution).
// Ports       : i_addr [7:0] input byte, o_data [7:0] substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Sbox (
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);

  // Entry 0 occupies the most significant byte of the packed table.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_ofs;

  assign w_bit_ofs = 11'd2047 - {i_addr, 3'b000};
  assign o_data    = c_sbox[w_bit_ofs -: 8];

endmodule

`default_nettype wire

// File: rtl/aes128_key_sched.sv
// ============================================================================
// Module      : aes128_key_sched
// Description : Sequential AES-128 key expansion. Emits rk0..rk10 as one-cycle
//               pulses, 5 cycles per round, sharing a single S-box one byte
//               per cycle.
// Ports       : clk, rst_n (async active-low)
//               start / key[127:0]      - expansion request and cipher key
//               busy                    - expansion in progress
//               rk_valid / rk_idx / rk  - round-key pulse, index, key value
//               done                    - pulse with the final round key
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic         done
);

  state_t        r_state;
  logic [127:0]  r_rk;
  logic [3:0]    r_rk_idx;
  logic          r_rk_valid;
  logic          r_done;
  logic [31:0]   r_tmp;
  logic [3:0]    r_round;
  logic [1:0]    r_bcnt;

  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [7:0]    w_sbox_in, w_sbox_out;
  logic [31:0]   w_t, w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = get_word(r_rk, 2'd0);
  assign w_w1 = get_word(r_rk, 2'd1);
  assign w_w2 = get_word(r_rk, 2'd2);
  assign w_w3 = get_word(r_rk, 2'd3);

  // The current round key's w3 feeds the S-box; it stays stable through SUB.
  assign w_sbox_in = rot_byte(w_w3, r_bcnt);

  Sbox u_sbox (
    .i_addr (w_sbox_in),
    .o_data (w_sbox_out)
  );

  // Next round key: each word chains off the freshly computed previous word.
  assign w_t  = r_tmp ^ {rcon(r_round), 24'h000000};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rk       <= '0;
      r_rk_idx   <= '0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_tmp      <= '0;
      r_round    <= '0;
      r_bcnt     <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rk       <= key;
            r_rk_idx   <= 4'd0;
            r_rk_valid <= 1'b1;
            r_round    <= 4'd1;
            r_bcnt     <= 2'd0;
            r_state    <= ST_SUB;
          end
        end
        ST_SUB: begin
          case (r_bcnt)
            2'd0:    r_tmp[31:24] <= w_sbox_out;
            2'd1:    r_tmp[23:16] <= w_sbox_out;
            2'd2:    r_tmp[15:8]  <= w_sbox_out;
            default: r_tmp[7:0]   <= w_sbox_out;
          endcase
          r_bcnt <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            r_state <= ST_MIX;
          end
        end
        ST_MIX: begin
          r_rk       <= {w_n0, w_n1, w_n2, w_n3};
          r_rk_idx   <= r_round;
          r_rk_valid <= 1'b1;
          if (r_round == 4'(AES_NR)) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_round <= r_round + 4'd1;
            r_bcnt  <= 2'd0;
            r_state <= ST_SUB;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign rk_valid = r_rk_valid;
  assign rk_idx   = r_rk_idx;
  assign rk       = r_rk;
  assign done     = r_done;

endmodule

`default_nettype wire
